// File: rtl/pipe_pkg.sv
// Shared types for the wideword pipeline hazard controller: FSM encoding,
// forwarding-select constants and the shadow scoreboard entry.
package pipe_pkg;

  // Widest register address the scoreboard stores; narrower addresses are zero-extended.
  localparam int SB_RD_W = 8;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_LDWAIT = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_EX = 2'd1;
  localparam logic [1:0] FWD_WB = 2'd2;

  typedef struct packed {
    logic [SB_RD_W-1:0] rd;
    logic               valid;
    logic               load;
  } sb_entry_t;

  // Youngest producer wins; a load in EX has no result yet, so it cannot forward.
  function automatic logic [1:0] fwd_sel(input logic ex_hit, input logic ex_load,
                                         input logic wb_hit);
    if (ex_hit && !ex_load) return FWD_EX;
    if (wb_hit)             return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Decode-side bundle between the ID stage and the hazard controller.
interface pipe_hazard_ctrl_if #(parameter int REG_AW = 5) ();

  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              id_regwren;
  logic              id_load;
  logic              halt_req;

  logic              pipe1_hold;
  logic              pipe2_bubble;
  logic [1:0]        fwd_a_sel;
  logic [1:0]        fwd_b_sel;
  logic              halted;
  logic [15:0]       stall_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_regwren, id_load,
           halt_req,
    input  pipe1_hold, pipe2_bubble, fwd_a_sel, fwd_b_sel, halted, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_regwren, id_load,
           halt_req,
    output pipe1_hold, pipe2_bubble, fwd_a_sel, fwd_b_sel, halted, stall_cnt
  );

endinterface

// File: rtl/hz_match.sv
// Compares one decode source register against the EX and WB scoreboard entries.
module hz_match
  import pipe_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic               use_rs,
  input  logic [REG_AW-1:0]  rs,
  input  logic               ex_valid,
  input  logic [SB_RD_W-1:0] ex_rd,
  input  logic               wb_valid,
  input  logic [SB_RD_W-1:0] wb_rd,
  output logic               ex_hit,
  output logic               wb_hit
);

  logic [SB_RD_W-1:0] rs_ext;

  assign rs_ext = SB_RD_W'(rs);
  assign ex_hit = use_rs & ex_valid & (ex_rd == rs_ext);
  assign wb_hit = use_rs & wb_valid & (wb_rd == rs_ext);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller: EX/WB shadow scoreboard, operand forwarding, load-use
// stall sequencing and drain-then-stop halt.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MEM_LAT = 2,
  parameter int REG_AW  = 5
) (
  input  logic               clk,
  input  logic               reset,
  pipe_hazard_ctrl_if.slave  bus
);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  sb_entry_t   sb_ex, sb_wb;
  logic        halt_pend;
  logic [15:0] stall_cnt;

  logic a_ex_hit, a_wb_hit, b_ex_hit, b_wb_hit;
  logic load_use, halt_any, hold, bubble, issue, hold_wb;

  hz_match #(.REG_AW(REG_AW)) u_match_a (
    .use_rs  (bus.id_valid & bus.id_use_rs1),
    .rs      (bus.id_rs1),
    .ex_valid(sb_ex.valid),
    .ex_rd   (sb_ex.rd),
    .wb_valid(sb_wb.valid),
    .wb_rd   (sb_wb.rd),
    .ex_hit  (a_ex_hit),
    .wb_hit  (a_wb_hit)
  );

  hz_match #(.REG_AW(REG_AW)) u_match_b (
    .use_rs  (bus.id_valid & bus.id_use_rs2),
    .rs      (bus.id_rs2),
    .ex_valid(sb_ex.valid),
    .ex_rd   (sb_ex.rd),
    .wb_valid(sb_wb.valid),
    .wb_rd   (sb_wb.rd),
    .ex_hit  (b_ex_hit),
    .wb_hit  (b_wb_hit)
  );

  assign load_use = (state == ST_RUN) & sb_ex.load & (a_ex_hit | b_ex_hit);
  assign halt_any = halt_pend | bus.halt_req;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    hold      = 1'b0;
    bubble    = 1'b0;
    case (state)
      ST_RUN: begin
        if (load_use) begin
          hold    = 1'b1;
          bubble  = 1'b1;
          cnt_nxt = 4'(MEM_LAT - 1);
          if (MEM_LAT > 1) state_nxt = ST_LDWAIT;
        end else if (halt_any) begin
          state_nxt = ST_DRAIN;
          cnt_nxt   = 4'd1;
        end
      end
      ST_LDWAIT: begin
        hold    = 1'b1;
        bubble  = 1'b1;
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          if (halt_any) begin
            state_nxt = ST_DRAIN;
            cnt_nxt   = 4'd1;
          end else begin
            state_nxt = ST_RUN;
          end
        end
      end
      ST_DRAIN: begin
        hold   = 1'b1;
        bubble = 1'b1;
        if (cnt == 4'd0) state_nxt = ST_HALTED;
        else             cnt_nxt   = cnt - 4'd1;
      end
      default: begin
        hold   = 1'b1;
        bubble = 1'b1;
      end
    endcase
  end

  assign issue = bus.id_valid & ~bubble & (state == ST_RUN);
  // The load stays parked in WB while memory data is outstanding, so the
  // dependent instruction sees a WB hit when it re-evaluates.
  assign hold_wb = (state == ST_LDWAIT) & sb_wb.load;

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    // NOTE: the scoreboard is a pair of flop entries, not a memory, so it is cleared on reset.
    if (reset) begin
      state     <= ST_RUN;
      cnt       <= '0;
      sb_ex     <= '0;
      sb_wb     <= '0;
      halt_pend <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (bus.halt_req) halt_pend <= 1'b1;
      if (bubble && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      if (state != ST_HALTED) begin
        if (!hold_wb) sb_wb <= sb_ex;
        if (issue) begin
          sb_ex.rd    <= SB_RD_W'(bus.id_rd);
          sb_ex.valid <= bus.id_regwren & bus.id_valid;
          sb_ex.load  <= bus.id_load;
        end else begin
          sb_ex <= '0;
        end
      end
    end
  end

  assign bus.pipe1_hold   = hold;
  assign bus.pipe2_bubble = bubble;
  assign bus.fwd_a_sel    = fwd_sel(a_ex_hit, sb_ex.load, a_wb_hit);
  assign bus.fwd_b_sel    = fwd_sel(b_ex_hit, sb_ex.load, b_wb_hit);
  assign bus.halted       = (state == ST_HALTED);
  assign bus.stall_cnt    = stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl (MEM_LAT=2); a driver queues the
// hand-computed expected outputs per cycle and a monitor compares them.
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic        hold;
    logic        bub;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        halted;
    logic [15:0] sc;
  } exp_t;

  logic clk;
  logic reset;

  pipe_hazard_ctrl_if #(.REG_AW(5)) bus ();

  pipe_hazard_ctrl #(.MEM_LAT(2), .REG_AW(5)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t ex(input logic hd, input logic bb, input int fa, input int fb,
                              input logic hl, input int sc);
    exp_t r;
    r.hold   = hd;
    r.bub    = bb;
    r.fa     = 2'(fa);
    r.fb     = 2'(fb);
    r.halted = hl;
    r.sc     = 16'(sc);
    return r;
  endfunction

  // One cycle of decode stimulus plus the outputs expected during that cycle.
  task automatic vec(input string nm, input logic rst, input logic v,
                     input int rs1, input int rs2, input logic u1, input logic u2,
                     input int rd, input logic w, input logic ld, input logic h,
                     input exp_t e);
    @(posedge clk);
    #1;
    reset          = rst;
    bus.id_valid   = v;
    bus.id_rs1     = 5'(rs1);
    bus.id_rs2     = 5'(rs2);
    bus.id_use_rs1 = u1;
    bus.id_use_rs2 = u2;
    bus.id_rd      = 5'(rd);
    bus.id_regwren = w;
    bus.id_load    = ld;
    bus.halt_req   = h;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  exp_t  mon_exp;
  exp_t  mon_act;
  string mon_name;

  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        mon_exp  = exp_q.pop_front();
        mon_name = name_q.pop_front();
        mon_act  = {bus.pipe1_hold, bus.pipe2_bubble, bus.fwd_a_sel, bus.fwd_b_sel,
                    bus.halted, bus.stall_cnt};
        checks++;
        if (mon_act !== mon_exp) begin
          errors++;
          $display("FAIL %s: got hold=%0b bub=%0b fa=%0d fb=%0d halted=%0b cnt=%h, want hold=%0b bub=%0b fa=%0d fb=%0d halted=%0b cnt=%h",
                   mon_name, mon_act.hold, mon_act.bub, mon_act.fa, mon_act.fb, mon_act.halted,
                   mon_act.sc, mon_exp.hold, mon_exp.bub, mon_exp.fa, mon_exp.fb,
                   mon_exp.halted, mon_exp.sc);
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1);
  end

  initial begin
    reset          = 1'b1;
    bus.id_valid   = 1'b0;
    bus.id_rs1     = '0;
    bus.id_rs2     = '0;
    bus.id_use_rs1 = 1'b0;
    bus.id_use_rs2 = 1'b0;
    bus.id_rd      = '0;
    bus.id_regwren = 1'b0;
    bus.id_load    = 1'b0;
    bus.halt_req   = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    //   name           rst v  rs1 rs2 u1 u2 rd w  ld h   hold bub fa fb halt cnt
    vec("reset_idle",   0, 0,  0,  0,  0, 0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0));
    // ALU dependency chain on r3, then r4
    vec("alu_prod_r3",  0, 1,  0,  0,  0, 0, 3, 1, 0, 0, ex(0, 0, 0, 0, 0, 0));
    vec("alu_fwd_ex",   0, 1,  3,  0,  1, 0, 4, 1, 0, 0, ex(0, 0, 1, 0, 0, 0));
    vec("alu_fwd_wb",   0, 1,  3,  4,  1, 1, 6, 1, 0, 0, ex(0, 0, 2, 1, 0, 0));
    vec("invalid_nofw", 0, 0,  6,  0,  1, 0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0));
    // Double hit on r7: EX wins on both sources
    vec("r7_first",     0, 1,  0,  0,  0, 0, 7, 1, 0, 0, ex(0, 0, 0, 0, 0, 0));
    vec("r7_second",    0, 1,  0,  0,  0, 0, 7, 1, 0, 0, ex(0, 0, 0, 0, 0, 0));
    vec("double_hit",   0, 1,  7,  7,  1, 1, 8, 0, 0, 0, ex(0, 0, 1, 1, 0, 0));
    vec("wb_only_hit",  0, 1,  7,  7,  1, 1, 0, 0, 0, 0, ex(0, 0, 2, 2, 0, 0));
    // r0 forwards like any other register
    vec("r0_prod",      0, 1,  0,  0,  0, 0, 0, 1, 0, 0, ex(0, 0, 0, 0, 0, 0));
    vec("r0_fwd_ex",    0, 1,  0,  0,  1, 0, 9, 0, 0, 0, ex(0, 0, 1, 0, 0, 0));
    vec("r0_fwd_wb",    0, 1,  0,  0,  0, 1, 0, 0, 0, 0, ex(0, 0, 0, 2, 0, 0));
    // Load-use on B: two bubbles, then WB forward
    vec("load_r5",      0, 1,  0,  0,  0, 0, 5, 1, 1, 0, ex(0, 0, 0, 0, 0, 0));
    vec("lu_detect",    0, 1,  0,  5,  0, 1, 10, 1, 0, 0, ex(1, 1, 0, 0, 0, 0));
    vec("lu_wait",      0, 1,  0,  5,  0, 1, 10, 1, 0, 0, ex(1, 1, 0, 2, 0, 1));
    vec("lu_release",   0, 1,  0,  5,  0, 1, 10, 1, 0, 0, ex(0, 0, 0, 2, 0, 2));
    vec("lu_idle",      0, 0,  0,  0,  0, 0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 2));
    // Halt raised in the second stall cycle
    vec("load_r11",     0, 1,  0,  0,  0, 0, 11, 1, 1, 0, ex(0, 0, 0, 0, 0, 2));
    vec("h_detect",     0, 1, 11,  0,  1, 0, 12, 1, 0, 0, ex(1, 1, 0, 0, 0, 2));
    vec("h_wait_req",   0, 1, 11,  0,  1, 0, 12, 1, 0, 1, ex(1, 1, 2, 0, 0, 3));
    vec("h_drain1",     0, 1, 11,  0,  1, 0, 12, 1, 0, 0, ex(1, 1, 2, 0, 0, 4));
    vec("h_drain2",     0, 1, 11,  0,  1, 0, 12, 1, 0, 0, ex(1, 1, 0, 0, 0, 5));
    vec("h_halted",     0, 1,  0,  0,  0, 0, 13, 1, 0, 0, ex(1, 1, 0, 0, 1, 6));
    vec("h_ignored",    0, 1, 13,  0,  1, 0, 0, 0, 0, 0, ex(1, 1, 0, 0, 1, 7));
    vec("h_reset",      1, 0,  0,  0,  0, 0, 0, 0, 0, 0, ex(1, 1, 0, 0, 1, 8));
    // Reset while in LDWAIT
    vec("r_load_r1",    0, 1,  0,  0,  0, 0, 1, 1, 1, 0, ex(0, 0, 0, 0, 0, 0));
    vec("r_detect",     0, 1,  1,  0,  1, 0, 2, 1, 0, 0, ex(1, 1, 0, 0, 0, 0));
    vec("r_wait_rst",   1, 1,  1,  0,  1, 0, 2, 1, 0, 0, ex(1, 1, 2, 0, 0, 1));
    vec("r_indep",      0, 1,  2,  0,  1, 0, 3, 1, 0, 0, ex(0, 0, 0, 0, 0, 0));
    vec("r_fwd_ex",     0, 1,  3,  0,  1, 0, 0, 0, 0, 0, ex(0, 0, 1, 0, 0, 0));
    // Halt in RUN while the current instruction issues
    vec("run_halt",     0, 1,  0,  0,  0, 0, 4, 1, 0, 1, ex(0, 0, 0, 0, 0, 0));
    vec("run_drain1",   0, 1,  4,  0,  1, 0, 0, 0, 0, 0, ex(1, 1, 1, 0, 0, 0));
    vec("run_drain2",   0, 1,  4,  0,  1, 0, 0, 0, 0, 0, ex(1, 1, 2, 0, 0, 1));
    vec("run_halted",   0, 1,  4,  0,  1, 0, 0, 0, 0, 0, ex(1, 1, 0, 0, 1, 2));
    // Every HALTED cycle is a bubble: run the counter up to saturation
    repeat (65531) @(posedge clk);
    vec("sat_fffe",     0, 1,  4,  0,  1, 0, 0, 0, 0, 0, ex(1, 1, 0, 0, 1, 16'hFFFE));
    vec("sat_ffff",     0, 1,  4,  0,  1, 0, 0, 0, 0, 0, ex(1, 1, 0, 0, 1, 16'hFFFF));
    vec("sat_hold",     0, 1,  4,  0,  1, 0, 0, 0, 0, 0, ex(1, 1, 0, 0, 1, 16'hFFFF));
    vec("sat_reset",    1, 0,  0,  0,  0, 0, 0, 0, 0, 0, ex(1, 1, 0, 0, 1, 16'hFFFF));
    // After reset the halt flag is gone and issue resumes normally
    vec("post_idle",    0, 0,  0,  0,  0, 0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0));
    vec("post_issue",   0, 1,  0,  0,  0, 0, 5, 1, 0, 0, ex(0, 0, 0, 0, 0, 0));
    vec("post_fwd",     0, 1,  5,  0,  1, 0, 0, 0, 0, 0, ex(0, 0, 1, 0, 0, 0));
    vec("post_run",     0, 0,  0,  0,  0, 0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0));

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_queue: got %0d unchecked vectors, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
